fifo_rd_stream_adapter: RTL and testbench



---
 rtl/fifo_rd_stream_adapter_if.sv | 40 ++++
 rtl/fifo_rd_stream_adapter.sv | 145 ++++++++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_adapter_if.sv
// Port bundle for fifo_rd_stream_adapter: FIFO read side plus valid/ready stream side.
// oTlast exists only when FIFO_RD_TLAST_EN is defined.
interface fifo_rd_stream_adapter_if #(
  parameter int pDataWidth = 8,
  parameter int pCntWidth  = 16
);
  logic                  iEnable;
  logic                  iFlush;
  logic                  oFifoRe;
  logic [pDataWidth-1:0] iFifoRd;
  logic                  iFifoRvd;
  logic                  iFifoEmp;
  logic [pDataWidth-1:0] oTdata;
  logic                  oTvalid;
  logic                  iTready;
  logic                  oBusy;
  logic [pCntWidth-1:0]  oWordCnt;
  logic                  oProtoErr;
`ifdef FIFO_RD_TLAST_EN
  logic                  oTlast;

  modport master (
    input  iEnable, iFlush, iFifoRd, iFifoRvd, iFifoEmp, iTready,
    output oFifoRe, oTdata, oTvalid, oBusy, oWordCnt, oProtoErr, oTlast
  );
  modport slave (
    output iEnable, iFlush, iFifoRd, iFifoRvd, iFifoEmp, iTready,
    input  oFifoRe, oTdata, oTvalid, oBusy, oWordCnt, oProtoErr, oTlast
  );
`else
  modport master (
    input  iEnable, iFlush, iFifoRd, iFifoRvd, iFifoEmp, iTready,
    output oFifoRe, oTdata, oTvalid, oBusy, oWordCnt, oProtoErr
  );
  modport slave (
    output iEnable, iFlush, iFifoRd, iFifoRvd, iFifoEmp, iTready,
    input  oFifoRe, oTdata, oTvalid, oBusy, oWordCnt, oProtoErr
  );
`endif
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream; FIFO read to oTvalid is 2 cycles.
// Reads stall while buffer plus in-flight word would overflow, so iTready backpressure never drops data. FIFO_RD_TLAST_EN adds oTlast.
module fifo_rd_stream_adapter #(
  parameter int pDataWidth = 8,
  parameter int pBufDepth  = 2,
  parameter int pCntWidth  = 16,
  parameter int pFrameLen  = 64
) (
  input logic                      iCLK,
  input logic                      iRST,
  fifo_rd_stream_adapter_if.master bus
);
  localparam int            PW    = $clog2(pBufDepth);
  localparam int            OW    = PW + 1;
  localparam logic [OW-1:0] DEPTH = OW'(pBufDepth);

  if (pBufDepth < 2 || pBufDepth > 8 || (pBufDepth & (pBufDepth - 1)) != 0) begin : g_bad_depth
    $error("pBufDepth must be a power of two in 2..8");
  end
  if (pFrameLen < 1 || pFrameLen > 65535) begin : g_bad_frame
    $error("pFrameLen must be in 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;
  state_t state_q, state_d;

  logic [pDataWidth-1:0] buf_q [pBufDepth];
  logic [pDataWidth-1:0] buf_d [pBufDepth];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]         occ_q, occ_d, occ_eff;
  logic                  inflight_q, inflight_d;
  logic                  ign_rvd_q, ign_rvd_d;
  logic                  err_q, err_d;
  logic [pCntWidth-1:0]  cnt_q, cnt_d;
  logic                  fifo_re, pop, push, drop, tvalid;

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.iFlush) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.iEnable) state_d = S_RUN;
        S_RUN:   if (!bus.iEnable) state_d = S_DRAIN;
        S_DRAIN: begin
          if (bus.iEnable)                          state_d = S_RUN;
          else if (!inflight_q && occ_q == '0)      state_d = S_IDLE;
        end
        S_FLUSH: state_d = bus.iEnable ? S_RUN : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The head word leaving this cycle frees its slot, which keeps depth 2 at one word per cycle.
  always_comb begin
    tvalid  = (occ_q != '0);
    pop     = tvalid & bus.iTready;
    drop    = bus.iFlush | (state_q == S_FLUSH);
    push    = bus.iFifoRvd & ~ign_rvd_q & ~drop & ((occ_q != DEPTH) | pop);
    occ_eff = occ_q - OW'(pop);
    fifo_re = (state_q == S_RUN) & ~bus.iFlush & ~bus.iFifoEmp
              & ((occ_eff + OW'(inflight_q)) < DEPTH);
  end

  always_comb begin
    buf_d    = buf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q + pCntWidth'(pop);
    if (bus.iFlush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        buf_d[wr_ptr_q] = bus.iFifoRd;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      occ_d = occ_q + OW'(1);
      else if (!push && pop) occ_d = occ_q - OW'(1);
    end
    inflight_d = fifo_re;
    // Landing data must match the read issued one cycle earlier, except just after reset.
    err_d      = err_q | (~ign_rvd_q & (bus.iFifoRvd != inflight_q));
    ign_rvd_d  = 1'b0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      ign_rvd_q  <= 1'b1;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      ign_rvd_q  <= ign_rvd_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge iCLK) begin
    buf_q <= buf_d;
  end

  assign bus.oFifoRe   = fifo_re;
  assign bus.oTvalid   = tvalid;
  assign bus.oTdata    = tvalid ? buf_q[rd_ptr_q] : '0;
  assign bus.oBusy     = (state_q != S_IDLE) | inflight_q | tvalid;
  assign bus.oWordCnt  = cnt_q;
  assign bus.oProtoErr = err_q;

`ifdef FIFO_RD_TLAST_EN
  logic [15:0] frame_q, frame_d;
  logic        tlast;

  always_comb begin
    tlast   = (frame_q == 16'(pFrameLen - 1));
    frame_d = frame_q;
    if (bus.iFlush)  frame_d = '0;
    else if (pop)    frame_d = tlast ? '0 : frame_q + 16'd1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) frame_q <= '0;
    else      frame_q <= frame_d;
  end

  assign bus.oTlast = tvalid & tlast;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter: a FIFO model feeds the read port, a monitor checks every presented word.
`timescale 1ns/1ps
module tb_fifo_rd_stream_adapter;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_stream_adapter_if #(.pDataWidth(DW), .pCntWidth(CW)) bus ();

  fifo_rd_stream_adapter #(
    .pDataWidth(DW), .pBufDepth(2), .pCntWidth(CW), .pFrameLen(FL)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: words staged in add_q enter the FIFO at the next edge; reads return one cycle later.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] add_q[$];
  logic [DW-1:0] exp_q[$];
  logic          emp_m = 1'b1;
  logic          rvd_m = 1'b0;
  logic [DW-1:0] rd_m  = '0;
  logic          spur_req = 1'b0;
  int            re_cnt = 0;

  assign bus.iFifoEmp = emp_m;
  assign bus.iFifoRvd = rvd_m;
  assign bus.iFifoRd  = rd_m;

  always @(posedge clk) begin
    while (add_q.size() > 0) fq.push_back(add_q.pop_front());
    rvd_m <= 1'b0;
    if (bus.oFifoRe) begin
      re_cnt++;
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL re_when_empty: got oFifoRe=1, expected 0 while FIFO empty at %0t", $time);
      end else begin
        rd_m  <= fq.pop_front();
        rvd_m <= 1'b1;
      end
    end
    if (spur_req) begin
      rd_m  <= 8'hEE;
      rvd_m <= 1'b1;
    end
    emp_m <= (fq.size() == 0);
  end

  // Monitor: compares the presented head word against the scoreboard every cycle it is valid.
  int hs_cnt = 0;
  int fidx   = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.oTvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", bus.oTdata, $time);
        end else begin
          check(bus.iTready ? "stream_data" : "held_data", bus.oTdata, exp_q[0]);
`ifdef FIFO_RD_TLAST_EN
          check("tlast", bus.oTlast, (fidx == FL - 1));
`endif
          if (bus.iTready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            fidx = (fidx == FL - 1) ? 0 : fidx + 1;
          end
        end
      end
      @(posedge clk);
      if (rst || bus.iFlush) fidx = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      add_q.push_back(DW'(base + i));
      exp_q.push_back(DW'(base + i));
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk);
    while (bus.oBusy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.oBusy, 0);
    tick();
  endtask

  initial begin
    int k, j, base;
    rst = 1'b1;
    bus.iEnable = 1'b0;
    bus.iFlush  = 1'b0;
    bus.iTready = 1'b0;
    tick(3);
    rst = 1'b0;

    @(negedge clk);
    check("rst_re",     bus.oFifoRe,   0);
    check("rst_valid",  bus.oTvalid,   0);
    check("rst_data",   bus.oTdata,    0);
    check("rst_busy",   bus.oBusy,     0);
    check("rst_cnt",    bus.oWordCnt,  0);
    check("rst_err",    bus.oProtoErr, 0);
    tick();

    // Full-rate stream of 8 words
    load(8'h01, 8);
    bus.iTready = 1'b1;
    bus.iEnable = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.oFifoRe && k < 20) begin @(negedge clk); k++; end
    check("t1_re_seen", (k < 20), 1);
    j = 0;
    while (!bus.oTvalid && j < 10) begin @(negedge clk); j++; end
    check("t1_latency", j, 2);
    for (int i = 0; i < 8; i++) begin
      check("t1_back_to_back", bus.oTvalid, 1);
      @(negedge clk);
    end
    check("t1_wordcnt", bus.oWordCnt, 8);
    tick();
    bus.iEnable = 1'b0;
    wait_idle("t1_idle");

    // Backpressure: only the buffer depth worth of reads while stalled
    bus.iTready = 1'b0;
    base = re_cnt;
    load(8'h10, 10);
    bus.iEnable = 1'b1;
    tick(20);
    check("t2_reads_stalled", re_cnt - base, 2);
    @(negedge clk);
    check("t2_valid_held", bus.oTvalid, 1);
    check("t2_head_word",  bus.oTdata, 8'h10);
    tick();
    bus.iTready = 1'b1;
    wait_drain("t2_drain");
    check("t2_wordcnt", bus.oWordCnt, 18);
    bus.iEnable = 1'b0;
    wait_idle("t2_idle");

    // Toggling ready with continuous supply
    load(8'h40, 12);
    bus.iEnable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.iTready = (i % 2 == 0);
      tick();
    end
    bus.iTready = 1'b1;
    wait_drain("t3_drain");
    check("t3_wordcnt",   bus.oWordCnt, 30);
    check("t3_handshake", hs_cnt, 30);
    bus.iEnable = 1'b0;
    wait_idle("t3_idle");

    // Enable dropped with one read in flight
    base = re_cnt;
    add_q.push_back(8'h50);
    add_q.push_back(8'h51);
    add_q.push_back(8'h52);
    exp_q.push_back(8'h50);
    bus.iEnable = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.oFifoRe && k < 20) begin @(negedge clk); k++; end
    bus.iEnable = 1'b0;
    check("t4_re_seen", (k < 20), 1);
    @(negedge clk);
    check("t4_busy_drain", bus.oBusy, 1);
    wait_idle("t4_idle");
    check("t4_reads",   re_cnt - base, 1);
    check("t4_wordcnt", bus.oWordCnt, 31);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_no_re", bus.oFifoRe, 0);
    end
    tick();
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    bus.iEnable = 1'b1;
    wait_drain("t4_leftover");
    bus.iEnable = 1'b0;
    wait_idle("t4_idle2");

    // Flush with one word buffered and one in flight
    bus.iTready = 1'b0;
    base = re_cnt;
    load(8'h60, 5);
    bus.iEnable = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.oTvalid && k < 20) begin @(negedge clk); k++; end
    bus.iFlush = 1'b1;
    check("t5_valid_seen", (k < 20), 1);
    @(posedge clk);
    #1;
    bus.iFlush = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    check("t5_reads", re_cnt - base, 2);
    @(negedge clk);
    check("t5_flushed", bus.oTvalid, 0);
    tick();
    bus.iTready = 1'b1;
    wait_drain("t5_drain");
    check("t5_wordcnt", bus.oWordCnt, 36);
    check("t5_err",     bus.oProtoErr, 0);
    bus.iEnable = 1'b0;
    wait_idle("t5_idle");

    // Spurious read-data valid
    exp_q.push_back(8'hEE);
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    tick(5);
    check("t6_err_set",  bus.oProtoErr, 1);
    check("t6_wordcnt",  bus.oWordCnt, 37);
    tick(10);
    check("t6_err_sticky", bus.oProtoErr, 1);
    check("t6_sb_empty",   exp_q.size(), 0);

    // Reset clears the error; a valid landing right after reset is ignored
    rst = 1'b1;
    spur_req = 1'b1;
    tick();
    rst = 1'b0;
    spur_req = 1'b0;
    @(negedge clk);
    check("t7_err_cleared", bus.oProtoErr, 0);
    check("t7_cnt_cleared", bus.oWordCnt, 0);
    @(negedge clk);
    check("t7_rvd_ignored_err",   bus.oProtoErr, 0);
    check("t7_rvd_ignored_valid", bus.oTvalid, 0);
    check("t7_idle_busy",         bus.oBusy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
